// File: rtl/avaliador_ativos_crauser.sv
// Active-node table with a sequential settle-threshold scan (Crauser OUT or Dijkstra rule).
// Optional threshold/population ports are enabled with macro AVALIADOR_LIMIAR_EN.
module avaliador_ativos_crauser #(
    parameter int unsigned NUM_ATIVOS  = 24,
    parameter int unsigned DIST_WIDTH  = 8,
    parameter int unsigned NODE_WIDTH  = 8,
    parameter int unsigned CUSTO_WIDTH = 8,
    parameter int unsigned MODO        = 0
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             ativar_in,
    input  logic [DIST_WIDTH-1:0]            ativar_distancia_in,
    input  logic [CUSTO_WIDTH-1:0]           ativar_menor_vizinho_in,
    input  logic [NODE_WIDTH-1:0]            ativar_endereco_no_in,
    input  logic                             remover_in,
    input  logic [NODE_WIDTH-1:0]            remover_endereco_no_in,
    input  logic                             ler_distancia_in,
    input  logic [NODE_WIDTH-1:0]            ler_endereco_in,
    output logic [DIST_WIDTH-1:0]            distancia_out,
    output logic                             distancia_hit_out,
    output logic                             cheio_out,
    output logic                             overflow_out,
    output logic                             tem_ativo_out,
    output logic [NUM_ATIVOS-1:0]            aprovados_out,
    output logic                             aprovados_valido_out,
    output logic [NUM_ATIVOS*NODE_WIDTH-1:0] slot_endereco_out
`ifdef AVALIADOR_LIMIAR_EN
    ,
    output logic [DIST_WIDTH:0]              limiar_out,
    output logic [$clog2(NUM_ATIVOS+1)-1:0]  num_ativos_out
`endif
);

    localparam int unsigned IdxW  = (NUM_ATIVOS > 1) ? $clog2(NUM_ATIVOS) : 1;
    localparam int unsigned CritW = DIST_WIDTH + 1;

    typedef enum logic [1:0] {StOcioso, StReduz, StAprova} estado_e;

    estado_e                 estado_q, estado_d;
    logic [NUM_ATIVOS-1:0]   valid_q, valid_d;
    logic [NODE_WIDTH-1:0]   addr_q [NUM_ATIVOS];
    logic [NODE_WIDTH-1:0]   addr_d [NUM_ATIVOS];
    logic [DIST_WIDTH-1:0]   dist_q [NUM_ATIVOS];
    logic [DIST_WIDTH-1:0]   dist_d [NUM_ATIVOS];
    logic [CUSTO_WIDTH-1:0]  mv_q   [NUM_ATIVOS];
    logic [CUSTO_WIDTH-1:0]  mv_d   [NUM_ATIVOS];
    logic                    ovf_q, ovf_d;
    logic                    cheio_q, tem_q;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [CritW-1:0]        limiar_q, limiar_d;
    logic [NUM_ATIVOS-1:0]   apr_q, apr_d, apr_calc;
    logic                    val_q, val_d;
    logic [DIST_WIDTH-1:0]   rd_dist_q, rd_dist_d;
    logic                    rd_hit_q, rd_hit_d;

    logic                    hit_a, hit_r, hit_l, livre, mesmo, modif;
    logic [IdxW-1:0]         idx_a, idx_r, idx_l, idx_livre;
    logic [CritW-1:0]        crit;

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        hit_a = 1'b0; idx_a = '0;
        hit_r = 1'b0; idx_r = '0;
        hit_l = 1'b0; idx_l = '0;
        livre = 1'b0; idx_livre = '0;
        for (int i = NUM_ATIVOS - 1; i >= 0; i--) begin
            if (valid_q[i] && addr_q[i] == ativar_endereco_no_in) begin
                hit_a = 1'b1; idx_a = IdxW'(i);
            end
            if (valid_q[i] && addr_q[i] == remover_endereco_no_in) begin
                hit_r = 1'b1; idx_r = IdxW'(i);
            end
            if (valid_q[i] && addr_q[i] == ler_endereco_in) begin
                hit_l = 1'b1; idx_l = IdxW'(i);
            end
            if (!valid_q[i]) begin
                livre = 1'b1; idx_livre = IdxW'(i);
            end
        end
    end

    // Insert uses the pre-remove free map, so a same-cycle remove cannot make room.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        dist_d  = dist_q;
        mv_d    = mv_q;
        ovf_d   = ovf_q;
        modif   = 1'b0;
        mesmo   = ativar_in && remover_in && (ativar_endereco_no_in == remover_endereco_no_in);
        if (ativar_in && !mesmo) begin
            if (hit_a) begin
                if (ativar_distancia_in < dist_q[idx_a]) begin
                    dist_d[idx_a] = ativar_distancia_in;
                    mv_d[idx_a]   = ativar_menor_vizinho_in;
                    modif         = 1'b1;
                end
            end else if (livre) begin
                valid_d[idx_livre] = 1'b1;
                addr_d[idx_livre]  = ativar_endereco_no_in;
                dist_d[idx_livre]  = ativar_distancia_in;
                mv_d[idx_livre]    = ativar_menor_vizinho_in;
                modif              = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (remover_in && hit_r) begin
            valid_d[idx_r] = 1'b0;
            modif          = 1'b1;
        end
    end

    always_comb begin
        rd_hit_d  = rd_hit_q;
        rd_dist_d = rd_dist_q;
        if (ler_distancia_in) begin
            rd_hit_d  = hit_l;
            rd_dist_d = hit_l ? dist_q[idx_l] : '0;
        end
    end

    always_comb begin
        if (MODO == 0) begin
            crit = CritW'(dist_q[idx_q]) + CritW'(mv_q[idx_q]);
        end else begin
            crit = CritW'(dist_q[idx_q]);
        end
        for (int i = 0; i < NUM_ATIVOS; i++) begin
            if (MODO == 0) begin
                apr_calc[i] = valid_q[i] && (CritW'(dist_q[i]) <= limiar_q);
            end else begin
                apr_calc[i] = valid_q[i] && (CritW'(dist_q[i]) == limiar_q);
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        limiar_d = limiar_q;
        apr_d    = apr_q;
        val_d    = val_q;
        unique case (estado_q)
            StOcioso: begin
                if (modif) begin
                    estado_d = StReduz;
                    idx_d    = '0;
                    limiar_d = '1;
                    val_d    = 1'b0;
                end
            end
            StReduz: begin
                if (modif) begin
                    idx_d    = '0;
                    limiar_d = '1;
                end else begin
                    if (valid_q[idx_q] && crit < limiar_q) limiar_d = crit;
                    if (idx_q == IdxW'(NUM_ATIVOS - 1)) estado_d = StAprova;
                    else idx_d = idx_q + IdxW'(1);
                end
            end
            StAprova: begin
                if (modif) begin
                    estado_d = StReduz;
                    idx_d    = '0;
                    limiar_d = '1;
                end else begin
                    apr_d    = apr_calc;
                    val_d    = 1'b1;
                    estado_d = StOcioso;
                end
            end
            default: estado_d = StOcioso;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            estado_q  <= StOcioso;
            valid_q   <= '0;
            for (int i = 0; i < NUM_ATIVOS; i++) begin
                addr_q[i] <= '0;
                dist_q[i] <= '0;
                mv_q[i]   <= '0;
            end
            ovf_q     <= 1'b0;
            cheio_q   <= 1'b0;
            tem_q     <= 1'b0;
            idx_q     <= '0;
            limiar_q  <= '0;
            apr_q     <= '0;
            val_q     <= 1'b0;
            rd_dist_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            dist_q    <= dist_d;
            mv_q      <= mv_d;
            ovf_q     <= ovf_d;
            cheio_q   <= &valid_d;
            tem_q     <= |valid_d;
            idx_q     <= idx_d;
            limiar_q  <= limiar_d;
            apr_q     <= apr_d;
            val_q     <= val_d;
            rd_dist_q <= rd_dist_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

`ifdef AVALIADOR_LIMIAR_EN
    localparam int unsigned CntW = $clog2(NUM_ATIVOS + 1);
    logic [CntW-1:0]  cnt_d, cnt_q;
    logic [CritW-1:0] lim_out_q;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_ATIVOS; i++) cnt_d = cnt_d + CntW'(valid_d[i]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q     <= '0;
            lim_out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (estado_q == StAprova && !modif) lim_out_q <= limiar_q;
        end
    end

    assign limiar_out     = lim_out_q;
    assign num_ativos_out = cnt_q;
`endif

    always_comb begin
        slot_endereco_out = '0;
        for (int i = 0; i < NUM_ATIVOS; i++) begin
            slot_endereco_out[i*NODE_WIDTH +: NODE_WIDTH] = addr_q[i];
        end
    end

    assign distancia_out        = rd_dist_q;
    assign distancia_hit_out    = rd_hit_q;
    assign cheio_out            = cheio_q;
    assign overflow_out         = ovf_q;
    assign tem_ativo_out        = tem_q;
    assign aprovados_out        = apr_q;
    assign aprovados_valido_out = val_q;

endmodule

// File: doc/avaliador_ativos_crauser.md
Name: avaliador_ativos_crauser

Overview:
- Registered active-node table for the shortest-path engine, with sequential threshold evaluation.
- Stores up to NUM_ATIVOS active nodes (address, distance, lightest outgoing edge).
- Scans the table to find the settle threshold, then flags every slot whose node can be settled this round.
- Sits between the relaxation unit, which activates and updates nodes, and the settle/expand controller, which consumes approvals and removes settled nodes.

Parameters:
- NUM_ATIVOS, 24, number of table slots.
- DIST_WIDTH, 8, distance width.
- NODE_WIDTH, 8, node address width.
- CUSTO_WIDTH, 8, edge cost width; must be <= DIST_WIDTH.
- MODO, 0, approval rule. 0 = Crauser OUT: dist <= min over actives of (dist + menor_vizinho). 1 = Dijkstra: dist == min over actives of dist.

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- ativar_in  input  1  insert or update request.
- ativar_distancia_in  input  DIST_WIDTH  tentative distance.
- ativar_menor_vizinho_in  input  CUSTO_WIDTH  lightest outgoing edge of the node.
- ativar_endereco_no_in  input  NODE_WIDTH  node address.
- remover_in  input  1  remove request.
- remover_endereco_no_in  input  NODE_WIDTH  node to remove.
- ler_distancia_in  input  1  read request.
- ler_endereco_in  input  NODE_WIDTH  node to read.
- distancia_out  output  DIST_WIDTH  read data.
- distancia_hit_out  output  1  read hit.
- cheio_out  output  1  all slots valid.
- overflow_out  output  1  sticky: an insert was dropped.
- tem_ativo_out  output  1  at least one slot valid.
- aprovados_out  output  NUM_ATIVOS  approved slot mask.
- aprovados_valido_out  output  1  aprovados_out is current.
- slot_endereco_out  output  NUM_ATIVOS*NODE_WIDTH  flattened slot addresses (slot i at bits [i*NODE_WIDTH +: NODE_WIDTH]).

Behaviour:
- Reset:
  - All slots invalid; FSM in OCIOSO.
  - All outputs 0, including overflow_out and slot_endereco_out.
- ativar, address already present:
  - Stored dist and menor_vizinho are replaced only if the new dist is strictly smaller.
  - Otherwise no change and no restart.
- ativar, address absent:
  - Written into the lowest-index free slot.
  - If the table is full, the request is dropped and overflow_out is set. overflow_out clears only on reset.
- remover: clears the valid bit of the matching slot. A miss is ignored.
- Same-cycle ativar and remover:
  - Same address: remover wins and ativar is ignored.
  - Different addresses: both are executed. A remove frees its slot only after the edge, so an insert into a full table in that cycle is dropped.
- Read:
  - 1-cycle latency; returns pre-update table contents.
  - Miss: distancia_out = 0, distancia_hit_out = 0.
  - Outputs hold until the next read.
- Table writes take effect at the clock edge. Any effective change (insert, improving update, hit remove) is a "modification".
- FSM:
  - OCIOSO: on modification -> REDUZ, index = 0, limiar = all ones, aprovados_valido_out = 0.
  - REDUZ: one slot per cycle. If valid, limiar = min(limiar, criterio), where criterio = dist + menor_vizinho (MODO 0) or dist (MODO 1). criterio is computed at DIST_WIDTH+1 bits with no wrap. A modification in REDUZ restarts at index 0. After index NUM_ATIVOS-1 -> APROVA.
  - APROVA: aprovados_out[i] = valid[i] && (dist[i] <= limiar for MODO 0, or dist[i] == limiar for MODO 1), registered. aprovados_valido_out = 1, -> OCIOSO. A modification in APROVA goes -> REDUZ and valido stays 0.
  - In OCIOSO with no modification, aprovados_out and aprovados_valido_out hold.
- Latency: last modification at cycle t -> aprovados_valido_out high from cycle t+NUM_ATIVOS+2.
- aprovados_valido_out drops in the cycle after any modification.
- Empty table: scan still runs and produces aprovados_out = 0, valido = 1, tem_ativo_out = 0.
- Asynchronous reset mid-scan aborts to OCIOSO and empties the table.
- cheio_out and tem_ativo_out are registered from the valid bits, so they track the table with no extra lag.

Optional Feature:
- Macro: AVALIADOR_LIMIAR_EN.
- Defined: adds ports limiar_out (DIST_WIDTH+1 bits, threshold latched in APROVA, reset 0) and num_ativos_out ($clog2(NUM_ATIVOS+1) bits, population count of valid slots, updated with the table, reset 0).
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- NUM_ATIVOS=4, MODO=0: activate nodes 1 (d=5, mv=3), 2 (d=7, mv=1), 3 (d=12, mv=2) -> limiar=8; aprovados_out=4'b0011 with valido at t+6 after the last activation.
- Update node 3 to d=6 -> valido drops, rescan, aprovados_out=4'b0111. Then update node 3 to d=9 -> ignored, valido stays 1.
- Fill 4 slots, activate a 5th node -> cheio_out=1, overflow_out=1, table unchanged. Remove node 1 and activate node 9 in the same cycle -> node 9 dropped.
- Same-cycle ativar and remover of node 2 -> node 2 absent; read of node 2 next cycle gives hit=0, distancia_out=0.
- Modification every 3rd cycle for 20 cycles -> valido never rises; after stopping, valido rises exactly NUM_ATIVOS+2 cycles after the last one.
- MODO=1, nodes at d=4, 4, 9 -> aprovados_out marks both d=4 slots. Reset asserted mid-REDUZ -> all outputs 0 immediately.
